// File: rtl/display_pkg.sv
// display_pkg: shared display constants, fade FSM encoding and clog2 helper
package display_pkg;
  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_OUT = 2'd1;
  localparam logic [1:0] FS_HOLD = 2'd2;
  localparam logic [1:0] FS_IN = 2'd3;
  localparam logic [1:0] FADE_BLACK = 2'd3;
  localparam logic [2:0] TITLE = 3'd0;
  localparam logic [2:0] STAGE = 3'd1;
  localparam logic [2:0] PAUSE = 3'd2;
  localparam logic [2:0] CLEAR = 3'd3;
  localparam logic [2:0] FAIL = 3'd4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-first priority encoder
module prio_enc #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign any = |req;
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: priority layer mux with enable, frame blink and fade FSM, 2-cycle latency
module layer_compositor
  import display_pkg::*;
#(
  parameter int NUM_LAYERS = 6,
  parameter int ADDR_W = 17,
  parameter int BLINK_FRAMES = 8,
  parameter int FADE_FRAMES = 4,
  localparam int SEL_W = clog2(NUM_LAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   h_cnt,
  input  logic [9:0]                   v_cnt,
  input  logic [NUM_LAYERS-1:0]        layer_hit,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS-1:0]        layer_blink,
  input  logic                         fade_req,
  input  logic                         fade_release,
  output logic [ADDR_W-1:0]            pixel_addr,
  output logic                         notBlank,
  output logic [SEL_W-1:0]             layer_sel,
  output logic [1:0]                   fade_level,
  output logic                         fade_black,
  output logic                         fade_busy
);
  localparam logic [7:0] BL = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] FL = 8'(FADE_FRAMES - 1);
  logic at0, at0_q, tick, bwrap, step, any, bph_q, bph_d, black_q, black_d, nb_q;
  logic [7:0] bcnt_q, bcnt_d, fcnt_q, fcnt_d;
  logic [1:0] state_q, state_d, lvl_q, lvl_d;
  logic [NUM_LAYERS-1:0] eff_q;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pix_q;
  logic [SEL_W-1:0] idx, sel_q;
  assign at0 = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign tick = at0 & ~at0_q;
  always_comb begin
    bwrap = tick && (bcnt_q == BL);
    bcnt_d = bwrap ? 8'd0 : tick ? bcnt_q + 8'd1 : bcnt_q;
    bph_d = bwrap ? ~bph_q : bph_q;
  end
  always_comb begin
    state_d = state_q;
    lvl_d = lvl_q;
    fcnt_d = fcnt_q;
    black_d = 1'b0;
    step = tick && (fcnt_q == FL);
    case (state_q)
      FS_IDLE: if (fade_req) begin
        state_d = FS_OUT;
        fcnt_d = 8'd0;
      end
      FS_OUT: if (tick) begin
        fcnt_d = step ? 8'd0 : fcnt_q + 8'd1;
        lvl_d = step ? lvl_q + 2'd1 : lvl_q;
        if (step && lvl_q == FADE_BLACK - 2'd1) begin
          state_d = FS_HOLD;
          black_d = 1'b1;
        end
      end
      FS_HOLD: if (fade_release) begin
        state_d = FS_IN;
        fcnt_d = 8'd0;
      end
      default: if (tick) begin
        fcnt_d = step ? 8'd0 : fcnt_q + 8'd1;
        lvl_d = step ? lvl_q - 2'd1 : lvl_q;
        if (step && lvl_q == 2'd1) state_d = FS_IDLE;
      end
    endcase
  end
  prio_enc #(.N(NUM_LAYERS), .W(SEL_W)) u_enc (.req(eff_q), .idx(idx), .any(any));
  // notBlank is masked with the level that appears on fade_level in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      at0_q <= 1'b0;
      bcnt_q <= 8'd0;
      bph_q <= 1'b1;
      state_q <= FS_IDLE;
      lvl_q <= 2'd0;
      fcnt_q <= 8'd0;
      black_q <= 1'b0;
      eff_q <= '0;
      addr_q <= '0;
      pix_q <= '0;
      sel_q <= '0;
      nb_q <= 1'b0;
    end else begin
      at0_q <= at0;
      bcnt_q <= bcnt_d;
      bph_q <= bph_d;
      state_q <= state_d;
      lvl_q <= lvl_d;
      fcnt_q <= fcnt_d;
      black_q <= black_d;
      eff_q <= layer_hit & layer_en & (~layer_blink | {NUM_LAYERS{bph_q}});
      addr_q <= layer_addr;
      pix_q <= any ? addr_q[int'(idx)*ADDR_W +: ADDR_W] : '0;
      sel_q <= idx;
      nb_q <= any && (lvl_d != FADE_BLACK);
    end
  end
  assign pixel_addr = pix_q;
  assign layer_sel = sel_q;
  assign notBlank = nb_q;
  assign fade_level = lvl_q;
  assign fade_black = black_q;
  assign fade_busy = (state_q != FS_IDLE);
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: randomized and directed checks against a frame-level reference model
module tb_layer_compositor;
  localparam int N = 6, A = 17, BF = 2, FF = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, fade_req = 1'b0, fade_release = 1'b0;
  logic [9:0] h_cnt = '0, v_cnt = '0;
  logic [N-1:0] layer_hit = '0, layer_en = '0, layer_blink = '0;
  logic [N*A-1:0] layer_addr = '0;
  logic [A-1:0] pixel_addr;
  logic notBlank, fade_black, fade_busy;
  logic [2:0] layer_sel;
  logic [1:0] fade_level;
  layer_compositor #(.NUM_LAYERS(N), .ADDR_W(A), .BLINK_FRAMES(BF), .FADE_FRAMES(FF)) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .layer_hit(layer_hit),
    .layer_addr(layer_addr), .layer_en(layer_en), .layer_blink(layer_blink),
    .fade_req(fade_req), .fade_release(fade_release), .pixel_addr(pixel_addr),
    .notBlank(notBlank), .layer_sel(layer_sel), .fade_level(fade_level),
    .fade_black(fade_black), .fade_busy(fade_busy));
  int nv = 0, nerr = 0, blacks = 0;
  bit stall = 0;
  int m_ticks = 0, m_mode = 0, m_mt = 0, m_lvl = 0;
  bit m_prev0 = 0, m_black = 0;
  logic [N-1:0] s1_eff = '0;
  logic [N*A-1:0] s1_addr = '0;
  logic [31:0] e_pix = 0, e_sel = 0, e_nb = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nv++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    bit at0, tk;
    logic [N-1:0] eff;
    int w;
    at0 = (h_cnt == 0) && (v_cnt == 0);
    tk = at0 && !m_prev0;
    if (rst) begin
      m_ticks = 0; m_mode = 0; m_mt = 0; m_lvl = 0; m_prev0 = 0; m_black = 0;
      s1_eff = '0; s1_addr = '0; e_pix = 0; e_sel = 0; e_nb = 0;
    end else begin
      eff = layer_hit & layer_en & (~layer_blink | {N{((m_ticks / BF) % 2) == 0}});
      m_black = 0;
      case (m_mode)
        0: if (fade_req) begin m_mode = 1; m_mt = 0; end
        1: if (tk) begin
          m_mt++; m_lvl = m_mt / FF;
          if (m_lvl == 3) begin m_mode = 2; m_black = 1; end
        end
        2: if (fade_release) begin m_mode = 3; m_mt = 0; end
        default: if (tk) begin
          m_mt++; m_lvl = 3 - m_mt / FF;
          if (m_lvl == 0) m_mode = 0;
        end
      endcase
      w = -1;
      for (int i = N - 1; i >= 0; i--) if (s1_eff[i]) w = i;
      e_pix = (w < 0) ? 0 : 32'(s1_addr[w*A +: A]);
      e_sel = (w < 0) ? 0 : w;
      e_nb = (w >= 0 && m_lvl != 3) ? 1 : 0;
      s1_eff = eff; s1_addr = layer_addr;
      if (tk) m_ticks++;
      m_prev0 = at0;
    end
    @(posedge clk);
    #1;
    chk("pixel_addr", 32'(pixel_addr), e_pix);
    chk("layer_sel", 32'(layer_sel), e_sel);
    chk("notBlank", 32'(notBlank), e_nb);
    chk("fade_level", 32'(fade_level), m_lvl);
    chk("fade_black", 32'(fade_black), 32'(m_black));
    chk("fade_busy", 32'(fade_busy), (m_mode != 0) ? 1 : 0);
    if (fade_black) blacks++;
    if (!stall) begin
      h_cnt = (h_cnt == 9) ? 10'd0 : h_cnt + 10'd1;
      if (h_cnt == 0) v_cnt = (v_cnt == 1) ? 10'd0 : v_cnt + 10'd1;
    end
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  task automatic pulse_req();
    fade_req = 1; cycle(); fade_req = 0;
  endtask
  task automatic rand_layers();
    layer_hit = N'($urandom); layer_en = N'($urandom) | N'($urandom);
    layer_blink = N'($urandom) & N'($urandom);
    for (int i = 0; i < N; i++) layer_addr[i*A +: A] = A'($urandom);
    if ($urandom_range(0, 4) == 0) layer_hit = '0;
  endtask
  initial begin
    int b;
    run(3);
    chk("reset_pix", 32'(pixel_addr), 0);
    chk("reset_busy", 32'(fade_busy), 0);
    rst = 0;
    layer_en = '1; layer_hit = 6'b001100;
    for (int i = 0; i < N; i++) layer_addr[i*A +: A] = A'(i * 100);
    run(3);
    chk("prio_addr", 32'(pixel_addr), 200);
    chk("prio_sel", 32'(layer_sel), 2);
    chk("prio_nb", 32'(notBlank), 1);
    layer_en = 6'b111011; layer_hit = 6'b000100;
    run(3);
    chk("mask_nb", 32'(notBlank), 0);
    chk("mask_addr", 32'(pixel_addr), 0);
    layer_hit = '0;
    run(3);
    chk("nohit_sel", 32'(layer_sel), 0);
    layer_en = '1; layer_blink = 6'b000010; layer_hit = 6'b000010;
    run(130);
    repeat (200) begin rand_layers(); cycle(); end
    layer_en = '1; layer_blink = '0; layer_hit = 6'b000001;
    blacks = 0;
    pulse_req();
    run(25);
    pulse_req();
    b = 0;
    while (m_mode != 2 && b < 400) begin cycle(); b++; end
    chk("reach_hold", 32'(fade_level), 3);
    chk("hold_nb", 32'(notBlank), 0);
    pulse_req();
    run(10);
    fade_release = 1;
    b = 0;
    while (fade_busy && b < 400) begin rand_layers(); cycle(); b++; end
    fade_release = 0;
    chk("fade_done", 32'(fade_busy), 0);
    chk("one_black", blacks, 1);
    run(3);
    stall = 1; h_cnt = 0; v_cnt = 0;
    run(8);
    stall = 0;
    fade_release = 1;
    while (!(h_cnt == 0 && v_cnt == 0)) cycle();
    pulse_req();
    repeat (300) begin rand_layers(); cycle(); end
    fade_release = 0;
    layer_hit = 6'b000001;
    pulse_req();
    b = 0;
    while (m_lvl != 2 && b < 400) begin cycle(); b++; end
    chk("mid_lvl", 32'(fade_level), 2);
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_lvl", 32'(fade_level), 0);
    chk("rst_busy", 32'(fade_busy), 0);
    chk("rst_nb", 32'(notBlank), 0);
    chk("rst_addr", 32'(pixel_addr), 0);
    layer_en = '1; layer_blink = 6'b000010; layer_hit = 6'b000010;
    stall = 1; h_cnt = 10'd5;
    run(3);
    chk("rst_phase", 32'(notBlank), 1);
    stall = 0;
    repeat (300) begin rand_layers(); if ($urandom_range(0, 40) == 0) fade_req = 1; fade_release = ($urandom_range(0, 3) == 0); cycle(); fade_req = 0; end
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor to the fixed six-layer display mux. Takes N sprite/tile layer hit flags and ROM addresses and resolves them by priority: the lowest index wins.
- Adds a per-layer enable mask, frame-synchronous blinking (player hit-flash, locked-door flash) and a frame-paced fade-out/fade-in FSM for stage transitions.
- Outputs are registered, with a fixed 2-cycle latency. The block sits between the draw_* units and the pixel ROM/VGA colour path.

Parameters:
- NUM_LAYERS, 6, number of input layers; index 0 has the highest priority.
- ADDR_W, 17, width of each layer's pixel address.
- BLINK_FRAMES, 8, number of frames per blink half-period (range 1..255).
- FADE_FRAMES, 4, number of frames per fade level step (range 1..255).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  VGA horizontal counter.
- v_cnt  in  10  VGA vertical counter.
- layer_hit  in  NUM_LAYERS  bit i set means layer i covers the current pixel.
- layer_addr  in  NUM_LAYERS*ADDR_W  flat bus; layer i occupies bits [i*ADDR_W +: ADDR_W].
- layer_en  in  NUM_LAYERS  per-layer enable; a layer with this bit at 0 is never selected.
- layer_blink  in  NUM_LAYERS  layer i is suppressed while blink_phase is 0.
- fade_req  in  1  single-cycle pulse that starts a fade-out.
- fade_release  in  1  level signal that starts the fade-in from the HOLD state.
- pixel_addr  out  ADDR_W  address of the winning layer, or 0 when no layer wins.
- notBlank  out  1  a layer won and fade_level is below 3.
- layer_sel  out  clog2(NUM_LAYERS)  index of the winning layer, or 0 when no layer wins.
- fade_level  out  2  0 = normal, 3 = black; consumed by the colour scaler.
- fade_black  out  1  one-cycle pulse on entry to HOLD.
- fade_busy  out  1  fade FSM is not in IDLE.

Behaviour:
- Reset state:
  - All outputs are 0.
  - blink_phase = 1, frame-related counters = 0, FSM = IDLE.
  - The pipeline registers hold hit = 0.
- Frame start (frame_tick):
  - frame_tick is a one-cycle internal pulse, raised when (h_cnt==0 && v_cnt==0) is true and was false on the previous cycle.
  - A stalled counter held at 0/0 therefore produces exactly one tick.
- Pipeline stage 1 (cycle 1):
  - Register eff_hit[i] = layer_hit[i] & layer_en[i] & (~layer_blink[i] | blink_phase).
  - Register layer_addr.
- Pipeline stage 2 (cycle 2):
  - A priority encoder selects the lowest set index of eff_hit.
  - Register pixel_addr, layer_sel and notBlank.
  - Total latency is exactly 2 clocks, with no bubbles and one pixel per clock.
- No winning layer (eff_hit all 0): pixel_addr = 0, layer_sel = 0, notBlank = 0.
- Fade masking:
  - notBlank is additionally forced to 0 when fade_level == 3.
  - It uses the fade_level value registered in the same cycle as stage 2.
- Blink counter:
  - Increments on each frame_tick.
  - At BLINK_FRAMES-1 with a tick, it wraps to 0 and toggles blink_phase.
  - blink_phase only changes on a frame_tick, so there is never tearing mid-frame.
- Fade FSM states: IDLE, OUT, HOLD, IN.
- IDLE:
  - fade_level = 0.
  - fade_req moves the FSM to OUT and clears fade_cnt.
  - fade_req is ignored in every other state.
- OUT:
  - fade_cnt counts frame_ticks.
  - At FADE_FRAMES-1 with a tick, fade_cnt clears and fade_level increments.
  - When fade_level reaches 3, the FSM moves to HOLD and fade_black pulses for exactly one cycle.
- HOLD:
  - fade_level stays at 3.
  - When fade_release is 1, the FSM moves to IN and clears fade_cnt.
  - If fade_release is already high on HOLD entry, the FSM leaves HOLD on the next cycle.
- IN:
  - fade_level decrements on each step, using the same step pacing as OUT.
  - When fade_level reaches 0, the FSM moves to IDLE.
- fade_busy = (state != IDLE).
- fade_level changes only on frame_tick cycles.
- Reset mid-fade returns the FSM to IDLE with fade_level 0 on the next edge. No fade_black pulse is emitted.
- Simultaneous fade_req and frame_tick in IDLE: the FSM enters OUT, and that tick does not count toward fade_cnt.
- layer_en and layer_blink are sampled every cycle with no qualification, because the game logic changes them only during blanking.

Decomposition:
- Shared package display_pkg:
  - Fade state encoding and the FADE_BLACK = 2'd3 level.
  - Game-state constants TITLE..FAIL, moved out of the per-module localparams.
  - The clog2 function.
- One natural sub-module, prio_enc: parameterised lowest-index-first encoder with outputs idx and any.
- Frame-tick detection, the blink counter and the fade FSM stay in the top level.

Test Plan:
- Priority: layer_hit=6'b001100, layer_en=all 1, addrs i*100. Required: 2 clocks later, pixel_addr=200, layer_sel=2, notBlank=1.
- Enable mask and no hit:
  - layer_en=6'b111011 with hit=6'b000100 -> notBlank=0, pixel_addr=0.
  - Then hit=0 -> outputs stay 0.
- Blink: BLINK_FRAMES=2, layer_blink[1]=1, hit=6'b000010.
  - Required: notBlank=1 for frames 0-1, 0 for frames 2-3, 1 for frames 4-5.
  - Transitions occur only on the cycle after h_cnt=v_cnt=0.
- Fade cycle: FADE_FRAMES=2, pulse fade_req.
  - Required: fade_level steps 1,2,3 at frames 2,4,6; fade_black pulses once; notBlank=0 while in HOLD.
  - Then assert fade_release: level goes 2,1,0 and fade_busy drops.
- Ignored request: pulse fade_req during OUT and again during HOLD. Required: step timing is unchanged and there is no second fade_black pulse.
- Reset mid-fade: assert rst while fade_level=2 in OUT. Required: next cycle fade_level=0, fade_busy=0, blink_phase=1, and all outputs are 0.
